// File: rtl/cull_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cull_sequencer
// Purpose  : Triangle-pipe stage ahead of rasterisation. Accepts one triangle
//            per valid/ready handshake and computes the sign of its signed area
//            with one shared multiplier over several cycles. It then applies
//            face-cull rules. Culled triangles are dropped silently. Survivors
//            are forwarded unchanged. Cull configuration is snapshotted per
//            triangle.
// Ports    : clk, rst_n (async assert, active-low)
//            s_valid/s_ready/s_pa/s_pb/s_pc   triangle input
//            m_valid/m_ready/m_pa/m_pb/m_pc   surviving triangle output
//            cfg_enable/cfg_mode/cfg_winding/cfg_origin  cull configuration
//            busy                             high whenever not idle
// Option   : CULL_SEQ_STATS_EN adds the following ports:
//            stats_clr, cull_count[31:0] and pass_count[31:0]
//            (saturating counters; clear wins over increment)
// Revision : 1.0  initial release
// ============================================================================
module cull_sequencer #(
   parameter int COORD_W = 33
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [2*COORD_W-1:0]   s_pa,
   input  logic [2*COORD_W-1:0]   s_pb,
   input  logic [2*COORD_W-1:0]   s_pc,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [2*COORD_W-1:0]   m_pa,
   output logic [2*COORD_W-1:0]   m_pb,
   output logic [2*COORD_W-1:0]   m_pc,
   input  logic                   cfg_enable,
   input  logic [1:0]             cfg_mode,
   input  logic                   cfg_winding,
   input  logic                   cfg_origin,
   output logic                   busy
`ifdef CULL_SEQ_STATS_EN
   ,
   input  logic                   stats_clr,
   output logic [31:0]            cull_count,
   output logic [31:0]            pass_count
`endif
);

   localparam int DW = COORD_W + 1;       // edge-vector width
   localparam int PW = 2*COORD_W + 2;     // product width
   localparam int AW = 2*COORD_W + 3;     // area width

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SUB    = 3'd1,
      S_MUL0   = 3'd2,
      S_MUL1   = 3'd3,
      S_DECIDE = 3'd4,
      S_OUT    = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_next;

   logic [2*COORD_W-1:0] r_pa, r_pb, r_pc;
   logic                 r_en, r_win, r_org;
   logic [1:0]           r_mode;
   logic [DW-1:0]        r_dx1, r_dy1, r_dx2, r_dy2;
   logic [PW-1:0]        r_p0, r_p1;

   logic [COORD_W-1:0]   w_xa, w_ya, w_xb, w_yb, w_xc, w_yc;
   logic [DW-1:0]        w_mul_a, w_mul_b;
   logic signed [PW-1:0] w_mul_a_x, w_mul_b_x, w_prod;
   logic [AW-1:0]        w_area;
   logic                 w_area_neg, w_cull_minus, w_cull;

   assign w_xa = r_pa[2*COORD_W-1:COORD_W];
   assign w_ya = r_pa[COORD_W-1:0];
   assign w_xb = r_pb[2*COORD_W-1:COORD_W];
   assign w_yb = r_pb[COORD_W-1:0];
   assign w_xc = r_pc[2*COORD_W-1:COORD_W];
   assign w_yc = r_pc[COORD_W-1:0];

   // Single shared multiplier: operands select the edge pair for this phase.
   assign w_mul_a   = (r_state == S_MUL0) ? r_dx1 : r_dx2;
   assign w_mul_b   = (r_state == S_MUL0) ? r_dy1 : r_dy2;
   assign w_mul_a_x = {{(PW-DW){w_mul_a[DW-1]}}, w_mul_a};
   assign w_mul_b_x = {{(PW-DW){w_mul_b[DW-1]}}, w_mul_b};
   assign w_prod    = w_mul_a_x * w_mul_b_x;

   assign w_area     = {r_p0[PW-1], r_p0} - {r_p1[PW-1], r_p1};
   assign w_area_neg = w_area[AW-1];   // zero area reads as positive

   // The four MINUS combinations of {origin, winding, mode[0]} are exactly
   // those with odd parity.
   assign w_cull_minus = r_org ^ r_win ^ r_mode[0];
   assign w_cull       = r_en && ((w_area_neg == w_cull_minus) || (r_mode == 2'b10));

   assign s_ready = (r_state == S_IDLE);
   assign m_valid = (r_state == S_OUT);
   assign busy    = (r_state != S_IDLE);
   assign m_pa    = r_pa;
   assign m_pb    = r_pb;
   assign m_pc    = r_pc;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (s_valid) w_next = S_SUB;
         S_SUB:    w_next = S_MUL0;
         S_MUL0:   w_next = S_MUL1;
         S_MUL1:   w_next = S_DECIDE;
         S_DECIDE: w_next = w_cull ? S_IDLE : S_OUT;
         S_OUT:    if (m_ready) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pa    <= '0;
         r_pb    <= '0;
         r_pc    <= '0;
         r_en    <= 1'b0;
         r_mode  <= 2'b00;
         r_win   <= 1'b0;
         r_org   <= 1'b0;
         r_dx1   <= '0;
         r_dy1   <= '0;
         r_dx2   <= '0;
         r_dy2   <= '0;
         r_p0    <= '0;
         r_p1    <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (s_valid) begin
                  r_pa   <= s_pa;
                  r_pb   <= s_pb;
                  r_pc   <= s_pc;
                  r_en   <= cfg_enable;
                  r_mode <= cfg_mode;
                  r_win  <= cfg_winding;
                  r_org  <= cfg_origin;
               end
            end
            S_SUB: begin
               // One extra bit keeps every difference exact.
               r_dx1 <= {w_xb[COORD_W-1], w_xb} - {w_xa[COORD_W-1], w_xa};
               r_dy1 <= {w_yc[COORD_W-1], w_yc} - {w_ya[COORD_W-1], w_ya};
               r_dx2 <= {w_xc[COORD_W-1], w_xc} - {w_xa[COORD_W-1], w_xa};
               r_dy2 <= {w_yb[COORD_W-1], w_yb} - {w_ya[COORD_W-1], w_ya};
            end
            S_MUL0:  r_p0 <= w_prod;
            S_MUL1:  r_p1 <= w_prod;
            default: ;
         endcase
      end
   end

`ifdef CULL_SEQ_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cull_count <= '0;
         pass_count <= '0;
      end else if (stats_clr) begin
         cull_count <= '0;
         pass_count <= '0;
      end else begin
         if ((r_state == S_DECIDE) && w_cull && (cull_count != 32'hFFFF_FFFF))
            cull_count <= cull_count + 32'd1;
         if ((r_state == S_OUT) && m_ready && (pass_count != 32'hFFFF_FFFF))
            pass_count <= pass_count + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cull_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cull_sequencer
// Purpose  : Directed self-checking bench for cull_sequencer. Covers the
//            CULL_SEQ_STATS_EN counters when that macro is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_cull_sequencer;

   localparam int CW = 33;
   localparam logic signed [CW-1:0] CMIN = 33'sh1_0000_0000;
   localparam logic signed [CW-1:0] CMAX = 33'sh0_FFFF_FFFF;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          s_valid, s_ready, m_valid, m_ready, busy;
   logic [2*CW-1:0] s_pa, s_pb, s_pc, m_pa, m_pb, m_pc;
   logic          cfg_enable, cfg_winding, cfg_origin;
   logic [1:0]    cfg_mode;
`ifdef CULL_SEQ_STATS_EN
   logic          stats_clr;
   logic [31:0]   cull_count, pass_count;
`endif

   int checks = 0;
   int errors = 0;
   bit emitted;
   int lat;

   always #5 clk = ~clk;

   cull_sequencer #(.COORD_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready),
      .s_pa(s_pa), .s_pb(s_pb), .s_pc(s_pc),
      .m_valid(m_valid), .m_ready(m_ready),
      .m_pa(m_pa), .m_pb(m_pb), .m_pc(m_pc),
      .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
      .cfg_winding(cfg_winding), .cfg_origin(cfg_origin),
      .busy(busy)
`ifdef CULL_SEQ_STATS_EN
      , .stats_clr(stats_clr), .cull_count(cull_count), .pass_count(pass_count)
`endif
   );

   function automatic logic [2*CW-1:0] vtx(input logic signed [CW-1:0] x, input logic signed [CW-1:0] y);
      return {x, y};
   endfunction

   // Reference: 128-bit area and a literal table of the MINUS cull-sign cases.
   function automatic bit exp_cull(input logic [2*CW-1:0] a, b, c, input bit en,
                                   input logic [1:0] md, input bit wn, input bit og);
      logic signed [127:0] xa, ya, xb, yb, xc, yc, area;
      bit neg, minus;
      xa = $signed(a[2*CW-1:CW]); ya = $signed(a[CW-1:0]);
      xb = $signed(b[2*CW-1:CW]); yb = $signed(b[CW-1:0]);
      xc = $signed(c[2*CW-1:CW]); yc = $signed(c[CW-1:0]);
      area  = (xb - xa) * (yc - ya) - (xc - xa) * (yb - ya);
      neg   = (area < 0);
      minus = (!og && !wn &&  md[0]) || (og &&  wn &&  md[0]) ||
              (!og &&  wn && !md[0]) || (og && !wn && !md[0]);
      return en && ((neg == minus) || (md == 2'b10));
   endfunction

   // Present one triangle, scramble the inputs after acceptance, then watch
   // for m_valid (emitted) or s_ready (dropped). lat counts edges after the
   // accepting edge; -1 means nothing happened within the budget.
   task automatic drive_and_wait(input logic [2*CW-1:0] a, b, c, input bit en,
                                 input logic [1:0] md, input bit wn, input bit og);
      @(negedge clk);
      s_pa = a; s_pb = b; s_pc = c;
      cfg_enable = en; cfg_mode = md; cfg_winding = wn; cfg_origin = og;
      s_valid = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_pa = ~a; s_pb = ~b; s_pc = ~c;
      cfg_enable = ~en; cfg_mode = ~md; cfg_winding = ~wn; cfg_origin = ~og;
      emitted = 1'b0;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (m_valid) begin emitted = 1'b1; lat = k; break; end
         if (s_ready) begin lat = k; break; end
      end
   endtask

   task automatic take_output();
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         s_valid = 1'($urandom); m_ready = 1'($urandom);
         s_pa = {$urandom, $urandom, 2'($urandom)};
         s_pb = {$urandom, $urandom, 2'($urandom)};
         s_pc = {$urandom, $urandom, 2'($urandom)};
         cfg_enable = 1'($urandom); cfg_mode = 2'($urandom);
         cfg_winding = 1'($urandom); cfg_origin = 1'($urandom);
      end
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b exp 1", s_ready); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if ({m_pa, m_pb, m_pc} !== '0) begin errors++; $display("FAIL reset_m_p got %h exp 0", {m_pa, m_pb, m_pc}); end
      s_valid = 1'b0; m_ready = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_pass();
      logic [2*CW-1:0] a, b, c;
      a = vtx(0, 0); b = vtx(4, 0); c = vtx(0, 4);
      drive_and_wait(a, b, c, 1'b1, 2'b01, 1'b0, 1'b0);
      checks++; if (emitted !== 1'b1) begin errors++; $display("FAIL pass_emitted got %b exp 1", emitted); end
      checks++; if (lat != 4) begin errors++; $display("FAIL pass_latency got %0d exp 4", lat); end
      checks++; if ({m_pa, m_pb, m_pc} !== {a, b, c}) begin errors++; $display("FAIL pass_vertices got %h exp %h", {m_pa, m_pb, m_pc}, {a, b, c}); end
      checks++; if ({busy, s_ready} !== 2'b10) begin errors++; $display("FAIL pass_busy_ready got %b exp 10", {busy, s_ready}); end
      take_output();
      checks++; if ({m_valid, s_ready, busy} !== 3'b010) begin errors++; $display("FAIL pass_handshake got %b exp 010", {m_valid, s_ready, busy}); end
   endtask

   task automatic test_cull_back();
      drive_and_wait(vtx(0, 0), vtx(4, 0), vtx(0, 4), 1'b1, 2'b00, 1'b0, 1'b0);
      checks++; if (emitted !== 1'b0) begin errors++; $display("FAIL cull_back_emitted got %b exp 0", emitted); end
      checks++; if (lat != 4) begin errors++; $display("FAIL cull_back_ready_latency got %0d exp 4", lat); end
   endtask

   task automatic test_swap_modes();
      // B/C swapped: area -16
      drive_and_wait(vtx(0, 0), vtx(0, 4), vtx(4, 0), 1'b1, 2'b01, 1'b0, 1'b0);
      checks++; if (emitted !== 1'b0) begin errors++; $display("FAIL swap_front_emitted got %b exp 0", emitted); end
      drive_and_wait(vtx(0, 0), vtx(0, 4), vtx(4, 0), 1'b0, 2'b01, 1'b0, 1'b0);
      checks++; if (emitted !== 1'b1 || lat != 4) begin errors++; $display("FAIL swap_disabled got emitted=%b lat=%0d exp 1/4", emitted, lat); end
      if (emitted) take_output();
      drive_and_wait(vtx(0, 0), vtx(0, 4), vtx(4, 0), 1'b1, 2'b10, 1'b0, 1'b0);
      checks++; if (emitted !== 1'b0) begin errors++; $display("FAIL both_neg_emitted got %b exp 0", emitted); end
      drive_and_wait(vtx(0, 0), vtx(4, 0), vtx(0, 4), 1'b1, 2'b10, 1'b1, 1'b1);
      checks++; if (emitted !== 1'b0) begin errors++; $display("FAIL both_pos_emitted got %b exp 0", emitted); end
      // BL + CW + front -> MINUS, so +16 survives; mode 11 acts as front.
      drive_and_wait(vtx(0, 0), vtx(4, 0), vtx(0, 4), 1'b1, 2'b11, 1'b1, 1'b1);
      checks++; if (emitted !== 1'b1) begin errors++; $display("FAIL mode11_bl_cw_emitted got %b exp 1", emitted); end
      if (emitted) take_output();
      // BL + ACW + back -> MINUS, so -16 is culled.
      drive_and_wait(vtx(0, 0), vtx(0, 4), vtx(4, 0), 1'b1, 2'b00, 1'b0, 1'b1);
      checks++; if (emitted !== 1'b0) begin errors++; $display("FAIL bl_acw_back_emitted got %b exp 0", emitted); end
   endtask

   task automatic test_stall();
      logic [2*CW-1:0] a, b, c;
      int bad;
      a = vtx(-7, 3); b = vtx(12, -5); c = vtx(1, 9);
      drive_and_wait(a, b, c, 1'b0, 2'b00, 1'b0, 1'b0);
      checks++; if (emitted !== 1'b1) begin errors++; $display("FAIL stall_emitted got %b exp 1", emitted); end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if ({m_valid, s_ready, m_pa, m_pb, m_pc} !== {1'b1, 1'b0, a, b, c}) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d unstable cycles exp 0", bad); end
      take_output();
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (m_valid !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL stall_single_transfer got %0d valid cycles exp 0", bad); end
   endtask

   task automatic test_extremes();
      logic [2*CW-1:0] av [6];
      logic [2*CW-1:0] bv [6];
      logic [2*CW-1:0] cv [6];
      logic [1:0] md [6];
      bit ec;
      av[0] = vtx(CMIN, CMIN); bv[0] = vtx(CMAX, CMIN); cv[0] = vtx(CMIN, CMAX); md[0] = 2'b01;
      av[1] = vtx(CMIN, CMIN); bv[1] = vtx(CMIN, CMAX); cv[1] = vtx(CMAX, CMIN); md[1] = 2'b01;
      av[2] = vtx(CMAX, CMAX); bv[2] = vtx(CMIN, CMAX); cv[2] = vtx(CMAX, CMIN); md[2] = 2'b00;
      av[3] = vtx(CMIN, CMAX); bv[3] = vtx(CMAX, CMIN); cv[3] = vtx(CMAX, CMAX); md[3] = 2'b01;
      // collinear: zero area is PLUS -> culled under back, kept under front
      av[4] = vtx(CMIN, CMIN); bv[4] = vtx(CMAX, CMAX); cv[4] = vtx(0, 0);       md[4] = 2'b00;
      av[5] = vtx(CMIN, CMIN); bv[5] = vtx(CMAX, CMAX); cv[5] = vtx(0, 0);       md[5] = 2'b01;
      for (int i = 0; i < 6; i++) begin
         ec = exp_cull(av[i], bv[i], cv[i], 1'b1, md[i], 1'b0, 1'b0);
         drive_and_wait(av[i], bv[i], cv[i], 1'b1, md[i], 1'b0, 1'b0);
         checks++;
         if (emitted !== !ec || lat != 4) begin
            errors++;
            $display("FAIL extreme_%0d got emitted=%b lat=%0d exp emitted=%b lat=4", i, emitted, lat, !ec);
         end
         if (emitted) take_output();
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      s_pa = vtx(0, 0); s_pb = vtx(4, 0); s_pc = vtx(0, 4);
      cfg_enable = 1'b0; cfg_mode = 2'b00; cfg_winding = 1'b0; cfg_origin = 1'b0;
      s_valid = 1'b1;
      @(posedge clk); #1; s_valid = 1'b0;
      @(posedge clk); @(posedge clk);
      @(negedge clk); rst_n = 1'b0; #1;
      checks++;
      if ({s_ready, m_valid, busy, m_pa, m_pb, m_pc} !== {1'b1, 1'b0, 1'b0, {(6*CW){1'b0}}}) begin
         errors++;
         $display("FAIL reset_mid got ready=%b valid=%b busy=%b exp 1/0/0 with zero vertices", s_ready, m_valid, busy);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 6; i++) @(posedge clk);
      #1;
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_discard got %b exp 0", m_valid); end
   endtask

`ifdef CULL_SEQ_STATS_EN
   task automatic test_stats();
      @(negedge clk); stats_clr = 1'b1;
      @(negedge clk); stats_clr = 1'b0;
      checks++; if ({cull_count, pass_count} !== 64'd0) begin errors++; $display("FAIL stats_clear0 got %0d/%0d exp 0/0", cull_count, pass_count); end
      for (int i = 0; i < 3; i++)
         drive_and_wait(vtx(0, 0), vtx(4, 0), vtx(0, 4), 1'b1, 2'b10, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         drive_and_wait(vtx(0, 0), vtx(4, 0), vtx(0, 4), 1'b0, 2'b00, 1'b0, 1'b0);
         if (emitted) take_output();
      end
      checks++; if (cull_count !== 32'd3) begin errors++; $display("FAIL stats_cull got %0d exp 3", cull_count); end
      checks++; if (pass_count !== 32'd2) begin errors++; $display("FAIL stats_pass got %0d exp 2", pass_count); end
      @(negedge clk); stats_clr = 1'b1;
      @(negedge clk); stats_clr = 1'b0;
      checks++; if ({cull_count, pass_count} !== 64'd0) begin errors++; $display("FAIL stats_clear got %0d/%0d exp 0/0", cull_count, pass_count); end
   endtask
`endif

   initial begin
      s_valid = 1'b0; m_ready = 1'b0; rst_n = 1'b0;
      s_pa = '0; s_pb = '0; s_pc = '0;
      cfg_enable = 1'b0; cfg_mode = 2'b00; cfg_winding = 1'b0; cfg_origin = 1'b0;
`ifdef CULL_SEQ_STATS_EN
      stats_clr = 1'b0;
`endif
      test_reset();
      test_pass();
      test_cull_back();
      test_swap_modes();
      test_stall();
      test_extremes();
      test_reset_mid();
`ifdef CULL_SEQ_STATS_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
